axi4_lite_regfile_slave: RTL
============================

# axi4_lite_regfile_slave

Parametrised AXI4-Lite slave with full write and read channels backed by an internal register file of DEPTH words. Accepts AW and W independently, applies byte strobes, and returns BRESP/RRESP with SLVERR for out-of-range addresses. Sits between an AXI4-Lite master and control/status logic. Also exposes a one-cycle memory-write strobe and a flat view of all registers.

## Interface

Parameters:
- N, 32: data and address width; legal values 32 or 64.
- DEPTH, 16: number of N-bit registers; legal values 1..256.
- LSB (localparam): log2(N/8); byte-offset bits ignored in decode.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- R_n  in  1  reset; one clock, reset synchronous, active-low.
- awaddr  in  N  write byte address.
- awvalid  in  1 / awready  out  1  AW handshake.
- wdata  in  N  write data.
- wstrb  in  N/8  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  in  1 / wready  out  1  W handshake.
- bresp  out  2  00 OKAY, 10 SLVERR.
- bvalid  out  1 / bready  in  1  B handshake.
- araddr  in  N  read byte address.
- arvalid  in  1 / arready  out  1  AR handshake.
- rdata  out  N / rresp  out  2  read data and response.
- rvalid  out  1 / rready  in  1  R handshake.
- addr  out  N  word index of the last committed write, zero-extended.
- data  out  N  post-strobe register value of the last committed write.
- mem_strb  out  N/8  wstrb of the last committed write.
- mem_write_en  out  1  one-cycle pulse on each committed in-range write.
- regs_out  out  DEPTH*N  register k at bits [k*N+N-1:k*N].

## Operation

- Decode: idx = address[N-1:LSB]. In range iff idx < DEPTH. Address bits [LSB-1:0] are ignored; no alignment error.
- Write path state: aw_held and w_held flags with holding registers for awaddr and for wdata/wstrb. Handshakes occur on rising edges.
  - AW handshake (awvalid && awready): latch awaddr, set aw_held, drop awready.
  - W handshake: latch wdata/wstrb, set w_held, drop wready. AW and W may complete in either order or on the same edge.
  - Commit: occurs on the edge where aw_held && w_held && !bvalid.
    - In range: each byte with strb=1 is replaced in reg[idx]; mem_write_en=1; addr/data/mem_strb are updated; bresp=00.
    - Out of range: no register change; mem_write_en stays 0; bresp=10.
    - Both cases set bvalid and clear both held flags.
  - wstrb=0 in range: commit proceeds with no byte changed, mem_write_en=1, bresp=00.
  - B handshake (bvalid && bready): clear bvalid; set awready and wready. One write outstanding maximum.
- Read path, independent of the write path:
  - AR handshake: drop arready; set rvalid.
    - In range: rdata=reg[idx], rresp=00.
    - Out of range: rdata=0, rresp=10.
  - R handshake: clear rvalid; set arready. One read outstanding maximum.
- Write/read collision: an AR handshake on the same edge as a commit to the same idx returns the pre-write value. An AR handshake on any later edge returns the new value.
- bresp, rdata and rresp hold stable while their valid is high.

## Timing

- Reset is sampled on the rising edge when R_n=0. It clears:
  - all registers and held flags;
  - awready, wready, arready, bvalid, rvalid, mem_write_en;
  - bresp, rresp, rdata, addr, data, mem_strb.
  All outputs read 0 after that edge. In-flight transactions are discarded with no response.
- First edge with R_n=1 sets awready, wready and arready to 1.
- Write latency: last of AW/W handshakes at edge k gives commit at edge k+1. bvalid and mem_write_en are high after edge k+1. mem_write_en clears at edge k+2 unconditionally.
- B handshake at edge m: awready and wready are high after edge m. Back-to-back writes therefore take at least 3 cycles each.
- Read latency: AR handshake at edge k gives rvalid after edge k. R handshake at edge m gives arready after edge m.
- bready or rready held low: valid holds indefinitely. Readies remain low, so no new request on that channel is accepted.
- Master may raise valid before or after ready. Slave readies never depend combinationally on master valids.

## Test plan

- Reset then write (N=32, DEPTH=16): awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF, AW and W on the same cycle -> bvalid after 2 edges with bresp=00; mem_write_en pulses once with addr=2; regs_out[95:64]=0xDEADBEEF; read 0x08 -> rdata=0xDEADBEEF, rresp=00.
- Strobe merge: reg[3]=0x11223344, write 0xAABBCCDD with wstrb=0x5 -> reg[3]=0x11BB33DD.
- W three cycles before AW, then AW with bready held low for 4 cycles -> a single commit; bvalid held for all 4 cycles; awready and wready stay 0 until the B handshake.
- Out of range: write to 0x40 -> bresp=10, mem_write_en=0, regs_out unchanged; read 0x40 -> rdata=0, rresp=10.
- Collision: reg[1]=0x0, commit 0x55 to idx 1 on the same edge as an AR handshake to 0x04 -> rdata=0x0. Next read of 0x04 -> 0x55.
- Reset mid-operation: assert R_n=0 while aw_held=1 and rvalid=1 -> all outputs 0 after the edge; regs_out=0; no bvalid issued; readies return 1 one edge after release.

Source files
------------

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register-file slave.
// Master drives requests; slave drives readies and responses.
interface axi4_lite_regfile_slave_if #(
    parameter int N = 32
);
    logic [N-1:0]   awaddr;
    logic           awvalid;
    logic           awready;
    logic [N-1:0]   wdata;
    logic [N/8-1:0] wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [N-1:0]   araddr;
    logic           arvalid;
    logic           arready;
    logic [N-1:0]   rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave over a DEPTH-word register file.
// AW/W latched independently; commit one edge after both are held.
module axi4_lite_regfile_slave #(
    parameter int N     = 32,
    parameter int DEPTH = 16
) (
    input  logic                    CLK,
    input  logic                    R_n,
    axi4_lite_regfile_slave_if.slave bus,
    output logic [N-1:0]            addr,
    output logic [N-1:0]            data,
    output logic [N/8-1:0]          mem_strb,
    output logic                    mem_write_en,
    output logic [DEPTH*N-1:0]      regs_out
);
    localparam int B   = N / 8;
    localparam int LSB = $clog2(B);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem [DEPTH];
    logic          aw_held;
    logic          w_held;
    logic [N-1:0]  awaddr_h;
    logic [N-1:0]  wdata_h;
    logic [B-1:0]  wstrb_h;

    logic [N-1:0]  aw_word;
    logic [N-1:0]  ar_word;
    logic          aw_ok;
    logic          ar_ok;
    logic [IW-1:0] wi;
    logic [IW-1:0] ri;
    logic [N-1:0]  cur;
    logic [N-1:0]  merged;
    logic [N-1:0]  rd_val;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          ar_hs;
    logic          r_hs;
    logic          commit;
    logic          aw_held_nx;
    logic          w_held_nx;
    logic          bvalid_nx;
    logic          rvalid_nx;

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign regs_out[k*N +: N] = mem[k];
    end

    // Address decode, strobe merge and next-state of the handshake flags
    always_comb begin
        aw_word = awaddr_h >> LSB;
        ar_word = bus.araddr >> LSB;
        aw_ok   = aw_word < N'(DEPTH);
        ar_ok   = ar_word < N'(DEPTH);
        wi      = aw_word[IW-1:0];
        ri      = ar_word[IW-1:0];
        cur     = aw_ok ? mem[wi] : '0;
        rd_val  = ar_ok ? mem[ri] : '0;
        merged  = cur;
        for (int b = 0; b < B; b++) begin
            if (wstrb_h[b]) merged[8*b +: 8] = wdata_h[8*b +: 8];
        end
        aw_hs      = bus.awvalid && bus.awready;
        w_hs       = bus.wvalid && bus.wready;
        b_hs       = bus.bvalid && bus.bready;
        ar_hs      = bus.arvalid && bus.arready;
        r_hs       = bus.rvalid && bus.rready;
        commit     = aw_held && w_held && !bus.bvalid;
        aw_held_nx = !commit && (aw_held || aw_hs);
        w_held_nx  = !commit && (w_held || w_hs);
        bvalid_nx  = commit || (bus.bvalid && !b_hs);
        rvalid_nx  = ar_hs || (bus.rvalid && !r_hs);
    end

    // Channel state, register file and sideband outputs
    always_ff @(posedge CLK) begin
        if (!R_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            awaddr_h     <= '0;
            wdata_h      <= '0;
            wstrb_h      <= '0;
            bus.awready  <= 1'b0;
            bus.wready   <= 1'b0;
            bus.arready  <= 1'b0;
            bus.bvalid   <= 1'b0;
            bus.bresp    <= 2'b00;
            bus.rvalid   <= 1'b0;
            bus.rdata    <= '0;
            bus.rresp    <= 2'b00;
            mem_write_en <= 1'b0;
            addr         <= '0;
            data         <= '0;
            mem_strb     <= '0;
        end else begin
            aw_held      <= aw_held_nx;
            w_held       <= w_held_nx;
            bus.bvalid   <= bvalid_nx;
            bus.rvalid   <= rvalid_nx;
            bus.awready  <= !aw_held_nx && !bvalid_nx;
            bus.wready   <= !w_held_nx && !bvalid_nx;
            bus.arready  <= !rvalid_nx;
            mem_write_en <= commit && aw_ok;
            if (aw_hs) awaddr_h <= bus.awaddr;
            if (w_hs) begin
                wdata_h <= bus.wdata;
                wstrb_h <= bus.wstrb;
            end
            if (commit) begin
                bus.bresp <= aw_ok ? 2'b00 : 2'b10;
                if (aw_ok) begin
                    mem[wi]  <= merged;
                    addr     <= aw_word;
                    data     <= merged;
                    mem_strb <= wstrb_h;
                end
            end
            if (ar_hs) begin
                bus.rdata <= rd_val;
                bus.rresp <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule
